// File: rtl/vga_frame_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : vga_frame_ctrl
// Summary  : VGA sync/pixel generator with host-written pattern registers.
//            Define VGA_TEARFREE_EN to stage writes and commit them at B.
// Revision : 1.0 - initial release
// =============================================================================
module vga_frame_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        cfg_pending,
    output logic        frame_start,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC,
    output logic [15:0] VGAD
);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNCW = 10'(H_SYNC);
    localparam logic [9:0]  V_SYNCW = 10'(V_SYNC);
    localparam logic [9:0]  X_FIRST = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  X_LAST  = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  Y_FIRST = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  Y_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [15:0] FG_RST  = 16'hFFE0;

    if ((H_SYNC + H_BACK + H_ACTIVE + H_FRONT != H_TOTAL) ||
        (V_SYNC + V_BACK + V_ACTIVE + V_FRONT != V_TOTAL)) begin : g_bad_timing
        $error("vga_frame_ctrl: sync/porch/active widths do not sum to totals");
    end

    logic [9:0]  ch_q, ch_d, cv_q, cv_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] fg_q, fg_d, bg_q, bg_d;
    logic        en_q, en_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, fstart_q, fstart_d;
    logic [15:0] pix_q, pix_d;
    logic        boundary, accept, in_win;
    logic [9:0]  x_off, y_off;
    logic        unused_bits;

    assign boundary    = (ch_q == H_LAST) && (cv_q == V_LAST);
    assign accept      = cfg_valid && cfg_ready;
    assign x_off       = ch_q - X_FIRST;
    assign y_off       = cv_q - Y_FIRST;
    assign in_win      = (ch_q >= X_FIRST) && (ch_q <= X_LAST) &&
                         (cv_q >= Y_FIRST) && (cv_q <= Y_LAST);
    assign unused_bits = ^{x_off[4:0], y_off[9], y_off[2:0], frame_cnt_q[7:5]};

    always_comb begin
        ch_d        = ch_q + 10'd1;
        cv_d        = cv_q;
        frame_cnt_d = frame_cnt_q;
        if (ch_q == H_LAST) begin
            ch_d = '0;
            cv_d = (cv_q == V_LAST) ? '0 : cv_q + 10'd1;
        end
        if (boundary) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Pixel and syncs are computed from the current counters and registered,
    // so all four video outputs share the same one-cycle latency.
    always_comb begin
        pix_d = '0;
        case (mode_q)
            2'd0:    pix_d = fg_q;
            2'd1:    pix_d = x_off[6] ? bg_q : fg_q;
            2'd2:    pix_d = (x_off[5] ^ y_off[5]) ? bg_q : fg_q;
            default: pix_d = {x_off[9:5] + frame_cnt_q[4:0], y_off[8:3], fg_q[4:0]};
        endcase
        if (!(in_win && en_q)) begin
            pix_d = '0;
        end
        hsync_d  = (ch_q >= H_SYNCW);
        vsync_d  = (cv_q >= V_SYNCW);
        fstart_d = boundary;
    end

`ifdef VGA_TEARFREE_EN
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_PENDING = 1'b1} cfg_state_t;
    cfg_state_t  state_q, state_d;
    logic [1:0]  sh_mode_q, sh_mode_d;
    logic [15:0] sh_fg_q, sh_fg_d, sh_bg_q, sh_bg_d;
    logic        sh_en_q, sh_en_d;

    // Ready drops in B so a host write can never race the commit.
    assign cfg_ready   = !boundary;
    assign cfg_pending = (state_q == S_PENDING);

    always_comb begin
        state_d   = state_q;
        sh_mode_d = sh_mode_q;
        sh_fg_d   = sh_fg_q;
        sh_bg_d   = sh_bg_q;
        sh_en_d   = sh_en_q;
        mode_d    = mode_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        en_d      = en_q;
        if (accept) begin
            case (cfg_addr)
                2'd0: sh_mode_d = cfg_data[1:0];
                2'd1: sh_fg_d   = cfg_data;
                2'd2: sh_bg_d   = cfg_data;
                2'd3: sh_en_d   = cfg_data[0];
            endcase
        end
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_PENDING;
            end
            default: begin
                if (boundary) begin
                    mode_d  = sh_mode_q;
                    fg_d    = sh_fg_q;
                    bg_d    = sh_bg_q;
                    en_d    = sh_en_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_mode_q <= 2'd0;
            sh_fg_q   <= FG_RST;
            sh_bg_q   <= 16'h0000;
            sh_en_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_mode_q <= sh_mode_d;
            sh_fg_q   <= sh_fg_d;
            sh_bg_q   <= sh_bg_d;
            sh_en_q   <= sh_en_d;
        end
    end
`else
    assign cfg_ready   = 1'b1;
    assign cfg_pending = 1'b0;

    always_comb begin
        mode_d = mode_q;
        fg_d   = fg_q;
        bg_d   = bg_q;
        en_d   = en_q;
        if (accept) begin
            case (cfg_addr)
                2'd0: mode_d = cfg_data[1:0];
                2'd1: fg_d   = cfg_data;
                2'd2: bg_d   = cfg_data;
                2'd3: en_d   = cfg_data[0];
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            cv_q        <= '0;
            frame_cnt_q <= '0;
            mode_q      <= 2'd0;
            fg_q        <= FG_RST;
            bg_q        <= 16'h0000;
            en_q        <= 1'b1;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            fstart_q    <= 1'b0;
            pix_q       <= '0;
        end else begin
            ch_q        <= ch_d;
            cv_q        <= cv_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            en_q        <= en_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            fstart_q    <= fstart_d;
            pix_q       <= pix_d;
        end
    end

    assign VGA_HSYNC   = hsync_q;
    assign VGA_VSYNC   = vsync_q;
    assign frame_start = fstart_q;
    assign VGAD        = pix_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_vga_frame_ctrl
// Summary  : Self-checking bench for vga_frame_ctrl on a reduced raster.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_vga_frame_ctrl;
    localparam int HS = 8, HB = 4, HA = 72, HF = 4, HT = 88;
    localparam int VS = 2, VB = 3, VA = 40, VF = 2, VT = 47;
    localparam int F  = HT * VT;
    localparam int X0 = HS + HB;
    localparam int Y0 = VS + VB;
`ifdef VGA_TEARFREE_EN
    localparam bit TEARFREE = 1'b1;
`else
    localparam bit TEARFREE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_pending;
    logic        frame_start;
    logic        VGA_HSYNC;
    logic        VGA_VSYNC;
    logic [15:0] VGAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_frame_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_pending(cfg_pending),
        .frame_start(frame_start), .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
        .VGAD(VGAD)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: registers are a plain array indexed by address.
    int unsigned m_t;
    logic [15:0] m_act [4];
    logic [15:0] m_sh  [4];
    bit          m_pend, m_acc;
    int          e_ch, e_cv;
    logic [15:0] e_vgad;
    bit          e_hs, e_vs, e_fs, e_ready;

    function automatic logic [15:0] pattern(int x, int y, int frm);
        int          g;
        logic [15:0] fg, bg;
        fg = m_act[1];
        bg = m_act[2];
        if (m_act[3][0] == 1'b0) return 16'h0000;
        case (int'(m_act[0] % 4))
            0: return fg;
            1: return ((x / 64) % 2 == 1) ? bg : fg;
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? bg : fg;
            default: begin
                g = (((x / 32) + frm) % 32) * 2048 + ((y / 8) % 64) * 32 + int'(fg % 32);
                return 16'(g);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_act[0] = 16'h0000; m_act[1] = 16'hFFE0; m_act[2] = 16'h0000; m_act[3] = 16'h0001;
        for (int i = 0; i < 4; i++) m_sh[i] = m_act[i];
        m_pend = 0; m_acc = 0;
        e_vgad = 16'h0; e_hs = 0; e_vs = 0; e_fs = 0; e_ready = 1;
        e_ch = -1; e_cv = -1;
    endtask

    task automatic model_edge();
        int pos, frm;
        pos  = int'(m_t % F);
        frm  = int'((m_t / F) % 256);
        e_ch = pos % HT;
        e_cv = pos / HT;
        e_hs = (e_ch >= HS);
        e_vs = (e_cv >= VS);
        e_fs = (pos == F - 1);
        if (e_ch >= X0 && e_ch < X0 + HA && e_cv >= Y0 && e_cv < Y0 + VA)
            e_vgad = pattern(e_ch - X0, e_cv - Y0, frm);
        else
            e_vgad = 16'h0000;
        m_acc = cfg_valid && e_ready;
        if (m_acc) begin
            if (TEARFREE) begin
                m_sh[cfg_addr] = cfg_data;
                m_pend = 1;
            end else begin
                m_act[cfg_addr] = cfg_data;
            end
        end
        if (TEARFREE && e_fs && m_pend) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            m_pend = 0;
        end
        m_t++;
        e_ready = TEARFREE ? ((m_t % F) != F - 1) : 1'b1;
    endtask

    task automatic check_outputs();
        if (errors < 40) begin
            checks++;
            if ({VGAD, VGA_HSYNC, VGA_VSYNC, frame_start, cfg_ready, cfg_pending} !==
                {e_vgad, e_hs, e_vs, e_fs, e_ready, m_pend}) begin
                errors++;
                $display("FAIL cycle t=%0d ch=%0d cv=%0d: got vgad=%h hs=%b vs=%b fs=%b rdy=%b pend=%b, want vgad=%h hs=%b vs=%b fs=%b rdy=%b pend=%b",
                         m_t, e_ch, e_cv, VGAD, VGA_HSYNC, VGA_VSYNC, frame_start, cfg_ready,
                         cfg_pending, e_vgad, e_hs, e_vs, e_fs, e_ready, m_pend);
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cfg_write(logic [1:0] a, logic [15:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        m_acc = 0;
        while (!m_acc && n < 8) begin tick(); n++; end
        cfg_valid = 1'b0;
        if (!m_acc) timeout("cfg_write");
    endtask

    task automatic wait_shown(int x, int y);
        int n;
        n = 0;
        while (!(e_ch == x && e_cv == y) && n < 2 * F) begin tick(); n++; end
        if (n >= 2 * F) timeout("wait_shown");
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin tick(); n++; end while (!e_fs && n < F + 8);
        if (!e_fs) timeout("wait_frame_start");
    endtask

    task automatic wait_pos(int p);
        int n;
        n = 0;
        while (int'(m_t % F) != p && n < F + 8) begin tick(); n++; end
        if (n >= F + 8) timeout("wait_pos");
    endtask

    task automatic probe(string name, int x, int y, logic [15:0] want);
        wait_shown(X0 + x, Y0 + y);
        chk(name, {16'h0, VGAD}, {16'h0, want});
    endtask

    typedef struct packed {
        logic [15:0] mode;
        logic [15:0] fg;
        logic [15:0] bg;
        logic [15:0] ctrl;
    } cfg_t;

    typedef struct {
        int          cfg;
        int          x;
        int          y;
        logic [15:0] want;
    } probe_t;

    cfg_t   cfgs   [5];
    probe_t probes [15];
    int     hs_low, vs_low, vis_cnt, nz_cnt, fs_cnt, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfgs[0] = '{16'h0000, 16'hF800, 16'h001F, 16'h0001};
        cfgs[1] = '{16'h0001, 16'h1234, 16'hABCD, 16'h0001};
        cfgs[2] = '{16'h0002, 16'hF800, 16'h001F, 16'h0001};
        cfgs[3] = '{16'h0002, 16'hF800, 16'h001F, 16'hFFFE};
        cfgs[4] = '{16'hFFFC, 16'h07E0, 16'hFFFF, 16'hFFFF};
        probes[0]  = '{0,  0,  0, 16'hF800};
        probes[1]  = '{0, 70, 10, 16'hF800};
        probes[2]  = '{0, 71, 39, 16'hF800};
        probes[3]  = '{1, 63,  0, 16'h1234};
        probes[4]  = '{1, 64,  0, 16'hABCD};
        probes[5]  = '{1, 10, 20, 16'h1234};
        probes[6]  = '{2,  0,  0, 16'hF800};
        probes[7]  = '{2, 32,  0, 16'h001F};
        probes[8]  = '{2, 32, 32, 16'hF800};
        probes[9]  = '{3,  0,  0, 16'h0000};
        probes[10] = '{3, 32,  0, 16'h0000};
        probes[11] = '{3, 40, 39, 16'h0000};
        probes[12] = '{4, 71,  0, 16'h07E0};
        probes[13] = '{4,  5,  5, 16'h07E0};
        probes[14] = '{4,  0, 39, 16'h07E0};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {11'h0, VGAD, VGA_HSYNC, VGA_VSYNC, frame_start, cfg_ready, cfg_pending},
            {11'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1;

        // Two idle frames: sync duty and default fill.
        hs_low = 0; vs_low = 0; vis_cnt = 0; nz_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            hs_low  += int'(!VGA_HSYNC);
            vs_low  += int'(!VGA_VSYNC);
            vis_cnt += int'(VGAD == 16'hFFE0);
            nz_cnt  += int'(VGAD != 16'h0000);
            fs_cnt  += int'(frame_start);
        end
        chk("hsync_low_count", hs_low, 2 * VT * HS);
        chk("vsync_low_count", vs_low, 2 * VS * HT);
        chk("default_fg_count", vis_cnt, 2 * HA * VA);
        chk("nonzero_count", nz_cnt, 2 * HA * VA);
        chk("frame_start_count", fs_cnt, 2);

        // Configuration table: write mid-frame, check the following frame.
        wait_shown(X0, Y0 + 10);
        for (int c = 0; c < 5; c++) begin
            cfg_write(2'd0, cfgs[c].mode);
            cfg_write(2'd1, cfgs[c].fg);
            cfg_write(2'd2, cfgs[c].bg);
            cfg_write(2'd3, cfgs[c].ctrl);
            chk($sformatf("pending_cfg%0d", c), cfg_pending, TEARFREE ? 1 : 0);
            wait_fs();
            for (int p = 0; p < 15; p++) begin
                if (probes[p].cfg == c)
                    probe($sformatf("tbl_c%0d_p%0d", c, p), probes[p].x, probes[p].y, probes[p].want);
            end
        end

        // Write held across the frame boundary.
        wait_pos(F - 1);
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 16'h001F;
        chk("ready_in_B", cfg_ready, TEARFREE ? 0 : 1);
        tick();
        chk("ready_after_B", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("pending_after_B", cfg_pending, TEARFREE ? 1 : 0);
        probe("B_write_next_frame", 0, 0, TEARFREE ? 16'h07E0 : 16'h001F);
        wait_fs();
        probe("B_write_frame_after", 0, 0, 16'h001F);

        // Write accepted in B-1 commits at that B.
        wait_pos(F - 2);
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 16'hF81F;
        tick();
        cfg_valid = 1'b0;
        chk("pending_in_B", cfg_pending, TEARFREE ? 1 : 0);
        probe("Bm1_committed", 0, 0, 16'hF81F);

        // Asynchronous reset with outstanding writes.
        wait_shown(X0 + 20, Y0 + 12);
        cfg_write(2'd1, 16'hF800);
        cfg_write(2'd0, 16'h0002);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {11'h0, VGAD, VGA_HSYNC, VGA_VSYNC, frame_start, cfg_ready, cfg_pending},
            {11'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!VGA_HSYNC && n < HT);
        chk("hsync_restart", n, HS + 1);
        probe("post_reset_origin", 0, 0, 16'hFFE0);
        probe("post_reset_x40", 40, 0, 16'hFFE0);

        // Randomized traffic, starting in gradient mode.
        cfg_write(2'd0, 16'h0003);
        cfg_write(2'd3, 16'h0001);
        for (int i = 0; i < 2 * F; i++) begin
            if ($urandom_range(0, 199) == 0)
                cfg_write(2'($urandom_range(0, 3)), 16'($urandom));
            else
                tick();
        end

        // Write latency to the pixel bus.
        cfg_write(2'd0, 16'h0000);
        cfg_write(2'd3, 16'h0001);
        cfg_write(2'd1, 16'hF800);
        wait_fs();
        wait_shown(X0 + 20, Y0 + 5);
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 16'h07E0;
        chk("direct_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("direct_t1", VGAD, 16'hF800);
        tick();
        chk("direct_t2", VGAD, TEARFREE ? 16'hF800 : 16'h07E0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_frame_ctrl.md
# vga_frame_ctrl

Self-contained VGA 640x480 frame controller: generates the sync timing, sequences a small set of pixel-pattern configuration registers, and drives the RGB565 pixel bus. A host writes configuration through a valid/ready port into shadow registers. Shadow values are committed to the active set only at the frame boundary, so a frame never tears. The block sits between host/control logic and the VGA pins, replacing a free-running fixed-colour timing generator.

## Interface
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- cfg_valid  in  1  host write request
- cfg_ready  out  1  write accepted when valid&&ready
- cfg_addr  in  2  0=mode, 1=fg colour, 2=bg colour, 3=control (bit0 enable)
- cfg_data  in  16  write data
- cfg_pending  out  1  shadow holds uncommitted writes
- frame_start  out  1  one-cycle pulse at first clock of each frame
- VGA_HSYNC  out  1  horizontal sync, active low
- VGA_VSYNC  out  1  vertical sync, active low
- VGAD  out  16  RGB565 pixel

## Operation
- Counters: CH 0..H_TOTAL-1 wraps. CV advances when CH==H_TOTAL-1 and wraps at V_TOTAL-1. Boundary cycle B = (CH==H_TOTAL-1 && CV==V_TOTAL-1).
- Visible window: CH in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and CV in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
- Within the window, x = CH-(H_SYNC+H_BACK) (10 bits) and y = CV-(V_SYNC+V_BACK) (9 bits).
- Pattern (active mode[1:0]):
  - 0: fg everywhere.
  - 1: 64-px stripes, x[6] ? bg : fg.
  - 2: 32-px checker, (x[5]^y[5]) ? bg : fg.
  - 3: gradient {x[9:5]+frame_cnt[4:0] (mod 32), y[8:3], fg[4:0]}.
- Pixel is 0 outside the window, or when active enable=0. Syncs keep running in both cases.
- frame_cnt: 8-bit, increments at B, wraps at 255. Internal only.
- Config FSM:
  - IDLE: a write updates the shadow register and moves to PENDING.
  - PENDING: further writes overwrite the shadow. At B, copy all four shadow registers to active and return to IDLE.
- cfg_ready=1 except in cycle B, where it is 0. Writes and commits therefore never collide.
- cfg_pending=1 in PENDING.
- Unused cfg_data bits: mode takes [1:0]; control takes [0].
- Reset values:
  - counters 0, frame_cnt 0, FSM IDLE.
  - active and shadow: mode 0, fg 16'hFFE0, bg 16'h0000, enable 1.
  - VGA_HSYNC 0, VGA_VSYNC 0, VGAD 0, frame_start 0, cfg_pending 0, cfg_ready 1.
- Reset mid-operation discards shadow contents and restarts timing at CH=CV=0.

## Timing
- VGAD, VGA_HSYNC, VGA_VSYNC and frame_start are registered, one cycle after the counter state that produced them. All four stay mutually aligned.
- VGA_HSYNC = registered (CH >= H_SYNC): low for 96 clocks per line.
- VGA_VSYNC = registered (CV >= V_SYNC): low for 2 full lines per frame.
- frame_start is high in the cycle after B.
- Commit takes effect on the clock edge ending B. The first visible pixel of the next frame uses the new configuration.
- A write accepted in cycle B-1 is committed at that B.
- A write presented at B waits (ready=0), is accepted at B+1, and is committed at the following frame's B.

## Configuration
- VGA_TEARFREE_EN defined: shadow/commit behaviour as above.
- VGA_TEARFREE_EN undefined:
  - no shadow; an accepted write updates the active register directly on that clock edge.
  - the new value is visible on VGAD two cycles after acceptance.
  - cfg_pending is tied 0; cfg_ready is tied 1, including at B.

## Test plan
- Reset, run 2 frames, no writes:
  - VGA_HSYNC low 96 of every 800 clocks; VGA_VSYNC low 1600 of every 420000 clocks.
  - VGAD=16'hFFE0 for exactly 640 clocks on each of 480 lines, 0 elsewhere.
  - frame_start pulses once per 420000 clocks.
- Mid-frame writes mode=2, fg=16'hF800, bg=16'h001F (TEARFREE_EN):
  - cfg_pending=1 and VGAD stays 16'hFFE0 until frame end.
  - next frame: (0,0)=F800, (32,0)=001F, (32,32)=F800; cfg_pending=0.
- cfg_valid held high entering B:
  - cfg_ready=0 in B; the write is accepted at B+1.
  - the write is not visible in the next frame and appears in the frame after.
- Write control=0:
  - after commit, VGAD=0 for the entire frame; sync waveforms identical to scenario 1.
- Assert rst_n low mid-frame with pending writes:
  - outputs return to reset values immediately.
  - after release, VGAD=16'hFFE0 (old shadow discarded) and timing restarts at CH=CV=0.
- TEARFREE_EN undefined, write fg=16'h07E0 mid-line:
  - cfg_ready stays 1; VGAD shows 07E0 two cycles after acceptance.
